// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolve sequencer: drives the shared comparator, computes the target,
// redirects fetch with a flush, then reports to writeback. Optional macro: BRANCH_PRED_EN.
module branch_resolve_ctrl #(
  parameter int IALIGN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_imm,
  input  logic        req_pred_taken,
  output logic        bc_en,
  output logic [2:0]  bc_opcode,
  output logic [31:0] bc_in_1,
  output logic [31:0] bc_in_2,
  input  logic        bc_out,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc,
  output logic        flush,
  output logic        done_valid,
  output logic        done_taken,
  output logic [31:0] done_link,
  output logic        done_misalign,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMP, REDIR, RESP} state_t;

  localparam logic [1:0] T_BRANCH = 2'b00;
  localparam logic [1:0] T_JAL    = 2'b01;
  localparam logic [1:0] T_JALR   = 2'b10;

  state_t      state;
  logic [1:0]  r_type;
  logic [2:0]  r_funct3;
  logic [31:0] r_pc, r_rs1, r_rs2, r_imm;
  logic        r_taken;

  logic [31:0] target, link, redir_tgt;
  logic        act_taken, misalign, mis_taken, need_redir;

`ifdef BRANCH_PRED_EN
  logic        r_pred;
`else
  logic        pred_unused;
  assign pred_unused = req_pred_taken;
`endif

  always_comb begin
    target = ((r_type == T_JALR) ? r_rs1 : r_pc) + r_imm;
    if (r_type == T_JALR) target[0] = 1'b0;
    link = r_pc + 32'd4;

    case (r_type)
      T_BRANCH:     act_taken = bc_out;
      T_JAL, T_JALR: act_taken = 1'b1;
      default:      act_taken = 1'b0;   // reserved type resolves not-taken
    endcase

    if (IALIGN == 16) misalign = target[0];
    else              misalign = |target[1:0];
    mis_taken = act_taken & misalign;

`ifdef BRANCH_PRED_EN
    // Only a mispredict needs fetch fixed up; predicted-taken fallthrough goes to pc+4.
    need_redir = (act_taken != r_pred) & ~mis_taken;
    redir_tgt  = act_taken ? target : link;
`else
    need_redir = act_taken & ~misalign;
    redir_tgt  = target;
`endif
  end

  // Flush marks the exact cycle fetch takes the redirect.
  assign flush = redir_valid & redir_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      r_type        <= '0;
      r_funct3      <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_imm         <= '0;
      r_taken       <= 1'b0;
`ifdef BRANCH_PRED_EN
      r_pred        <= 1'b0;
`endif
      req_ready     <= 1'b1;
      bc_en         <= 1'b0;
      bc_opcode     <= '0;
      bc_in_1       <= '0;
      bc_in_2       <= '0;
      redir_valid   <= 1'b0;
      redir_pc      <= '0;
      done_valid    <= 1'b0;
      done_taken    <= 1'b0;
      done_link     <= '0;
      done_misalign <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_type    <= req_type;
            r_funct3  <= req_funct3;
            r_pc      <= req_pc;
            r_rs1     <= req_rs1;
            r_rs2     <= req_rs2;
            r_imm     <= req_imm;
`ifdef BRANCH_PRED_EN
            r_pred    <= req_pred_taken;
`endif
            // Comparator inputs are staged here so they are clean registers during CMP.
            if (req_type == T_BRANCH) begin
              bc_en     <= 1'b1;
              bc_opcode <= req_funct3;
              bc_in_1   <= req_rs1;
              bc_in_2   <= req_rs2;
            end
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CMP;
          end
        end

        CMP: begin
          bc_en     <= 1'b0;
          bc_opcode <= '0;
          bc_in_1   <= '0;
          bc_in_2   <= '0;
          r_taken   <= act_taken;
          if (need_redir) begin
            redir_valid <= 1'b1;
            redir_pc    <= redir_tgt;
            state       <= REDIR;
          end else begin
            done_valid    <= 1'b1;
            done_taken    <= act_taken;
            done_misalign <= mis_taken;
            done_link     <= link;
            state         <= RESP;
          end
        end

        REDIR: begin
          if (redir_ready) begin
            redir_valid   <= 1'b0;
            redir_pc      <= '0;
            done_valid    <= 1'b1;
            done_taken    <= r_taken;
            done_misalign <= 1'b0;
            done_link     <= link;
            state         <= RESP;
          end
        end

        RESP: begin
          done_valid    <= 1'b0;
          done_taken    <= 1'b0;
          done_misalign <= 1'b0;
          done_link     <= '0;
          req_ready     <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencer that owns the branch comparator in the multi-cycle RV32I core.
- Accepts branch/jump requests from decode via valid/ready, drives the comparator for one cycle, and computes the target.
- Issues a PC redirect plus flush to fetch, then reports completion to writeback (taken flag, link address, misalign fault).

Parameters:
- IALIGN, 32, instruction alignment in bits. 32: target bits [1:0] must be 00. 16: only bit 0 is checked, and it is always 0.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_type  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 reserved (treated as not-taken BRANCH)
- req_funct3  in  3  branch condition code
- req_pc  in  32  PC of the instruction
- req_rs1  in  32  rs1 value
- req_rs2  in  32  rs2 value
- req_imm  in  32  sign-extended immediate
- req_pred_taken  in  1  fetch prediction (used only with BRANCH_PRED_EN)
- bc_en  out  1  comparator enable
- bc_opcode  out  3  comparator condition code
- bc_in_1  out  32  comparator operand A
- bc_in_2  out  32  comparator operand B
- bc_out  in  1  comparator result (combinational)
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  32  new fetch PC
- flush  out  1  one-cycle pipeline flush pulse
- done_valid  out  1  one-cycle completion strobe
- done_taken  out  1  branch/jump resolved taken
- done_link  out  32  req_pc+4, for JAL/JALR rd
- done_misalign  out  1  taken target misaligned (instruction-address-misaligned fault)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async on rst_n low, released synchronously): state=IDLE. Every output is 0 except req_ready=1. All request registers are cleared. Reset mid-operation abandons the request with no redirect, flush or done.
- States: IDLE, CMP, REDIR, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields and go to CMP. req_ready=0 in every other state.
- CMP (exactly 1 cycle):
  - BRANCH: bc_en=1; bc_opcode, bc_in_1 and bc_in_2 driven from registered funct3, rs1, rs2. taken = bc_out sampled at the clock edge. funct3 010/011 yields not-taken (comparator returns 0).
  - JAL/JALR: bc_en=0, taken=1.
  - Outside CMP, bc_en=0 and bc_opcode/bc_in_1/bc_in_2 = 0.
- Target arithmetic, all 32-bit modulo 2^32, wrap permitted:
  - BRANCH and JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - done_link = pc+4.
- CMP exit:
  - taken and aligned: go to REDIR, registering redir_pc=target.
  - taken and misaligned: go to RESP with done_misalign=1; no redirect, no flush.
  - not taken: go to RESP.
- REDIR: redir_valid=1 and redir_pc held stable until redir_ready. In the handshake cycle flush=1 (single pulse), then go to RESP. Stalls on redir_ready are unbounded.
- RESP: done_valid=1 for 1 cycle with done_taken, done_link and done_misalign valid; then go to IDLE. done_* fields are cleared to 0 in IDLE.
- Latency (accept edge = cycle 0):
  - not-taken: done_valid in cycle 2.
  - taken with redir_ready held 1: redir_valid/flush in cycle 2, done_valid in cycle 3.
  - Throughput: one request per 3 cycles (not taken) or 4 cycles (taken) minimum.
- A new req_valid during busy is not accepted; the requester holds it.

Optional Feature:
- Macro: BRANCH_PRED_EN.
- Defined:
  - req_pred_taken is registered at accept.
  - Redirect and flush are issued only on mispredict (actual != predicted).
  - Predicted-taken but actually not-taken redirects to pc+4.
  - Correct prediction goes CMP to RESP directly.
  - JAL/JALR predicted not-taken redirect normally.
- Not defined: req_pred_taken is ignored; every aligned taken branch/jump redirects and flushes.

Test Plan:
- Reset: hold rst_n=0 mid-REDIR, release -> state IDLE, redir_valid=0, flush=0, req_ready=1, done_valid never asserts.
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1 -> bc_en=1 and bc_opcode=000 in cycle 1; redir_pc=0x120 and flush in cycle 2; done_valid cycle 3 with done_taken=1.
- BLT, rs1=0xFFFFFFFF, rs2=1 (signed -1<1) -> taken. BLTU with the same operands -> not taken: done_valid cycle 2, done_taken=0, no flush.
- JALR, rs1=0x203, imm=0 -> redir_pc=0x202 is misaligned (IALIGN=32) -> done_misalign=1, no redirect, done_link=pc+4.
- JAL, pc=0xFFFFFFF0, imm=0x20, redir_ready low 5 cycles -> redir_pc=0x00000010 held stable 5 cycles; flush exactly 1 cycle at handshake.
- With BRANCH_PRED_EN: BNE with pred_taken=1, rs1=rs2 -> redir_pc=pc+4 plus flush. Same case with pred_taken=0 -> no redirect, done cycle 2.
